serial_word_adder: RTL and testbench

SERIAL_WORD_ADDER -- requirements
Module: serial_word_adder

---
 rtl/serial_word_adder.sv | 101 ++++++++++
 tb/tb_serial_word_adder.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/serial_word_adder.sv
// Bit-serial, LSB-first two's-complement adder/subtractor. Each word's parallel
// result (word_sum, carry_out, overflow) is published one cycle after its MSB.
module serial_word_adder #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic         first,
  input  logic         sub,
  input  logic         a,
  input  logic         b,
  output logic         out_valid,
  output logic         sum,
  output logic         word_valid,
  output logic [W-1:0] word_sum,
  output logic         carry_out,
  output logic         overflow,
  output logic         frame_err
);

  localparam int IW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t        state, state_nx;
  logic [IW-1:0] idx, idx_cur;
  logic          carry, op;
  logic [W-2:0]  acc;

  logic          accept, last;
  logic          op_cur, c_in, b_x, s, c_nx;
  logic [W-1:0]  acc_nx;

  logic          out_valid_d, sum_d, word_valid_d, frame_err_d;

  // A first bit restarts the word from any state, so op/carry/idx come from the inputs.
  always_comb begin
    accept  = in_valid & (first | (state == ACTIVE));
    op_cur  = first ? sub : op;
    c_in    = first ? sub : carry;
    idx_cur = first ? '0 : idx;
    last    = accept & (idx_cur == IW'(W-1));
    b_x     = b ^ op_cur;
    s       = a ^ b_x ^ c_in;
    c_nx    = (a & b_x) | (a & c_in) | (b_x & c_in);
    acc_nx  = {1'b0, acc};
    if (accept) acc_nx[idx_cur] = s;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (accept) state_nx = last ? IDLE : ACTIVE;
  end

  always_comb begin
    out_valid_d  = accept;
    sum_d        = accept & s;
    word_valid_d = last;
    frame_err_d  = in_valid & ~first & (state == IDLE);
  end

  // Partial bits live in acc so word_sum keeps the previous word until completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx        <= '0;
      carry      <= 1'b0;
      op         <= 1'b0;
      acc        <= '0;
      out_valid  <= 1'b0;
      sum        <= 1'b0;
      word_valid <= 1'b0;
      word_sum   <= '0;
      carry_out  <= 1'b0;
      overflow   <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      out_valid  <= out_valid_d;
      sum        <= sum_d;
      word_valid <= word_valid_d;
      frame_err  <= frame_err_d;
      if (accept) begin
        op    <= op_cur;
        carry <= c_nx;
        idx   <= last ? '0 : idx_cur + 1'b1;
        acc   <= acc_nx[W-2:0];
      end
      if (last) begin
        word_sum  <= acc_nx;
        carry_out <= c_nx;
        overflow  <= c_in ^ c_nx;
      end
    end
  end

endmodule

// File: tb/tb_serial_word_adder.sv
// Randomized bench for serial_word_adder; word results predicted with plain
// integer arithmetic and compared cycle by cycle.
module tb_serial_word_adder;
  localparam int W = 8;
  localparam logic [31:0] MASK = (32'd1 << W) - 1;

  logic         clk = 1'b0, rst = 1'b1;
  logic         in_valid = 1'b0, first = 1'b0, sub = 1'b0, a = 1'b0, b = 1'b0;
  logic         out_valid, sum, word_valid, carry_out, overflow, frame_err;
  logic [W-1:0] word_sum;

  int checks = 0, errors = 0;
  logic [31:0] exp_ws = '0;
  logic        exp_co = 1'b0, exp_of = 1'b0;

  serial_word_adder #(.W(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .first(first), .sub(sub),
    .a(a), .b(b), .out_valid(out_valid), .sum(sum), .word_valid(word_valid),
    .word_sum(word_sum), .carry_out(carry_out), .overflow(overflow),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Apply inputs for one cycle, then sample 1ns after the edge.
  task automatic cyc(input logic iv, input logic f, input logic sb, input logic aa, input logic bb);
    in_valid = iv; first = f; sub = sb; a = aa; b = bb;
    @(posedge clk); #1;
  endtask

  task automatic chk_out(input logic ov, input logic sv, input logic wv, input logic fe);
    chk("out_valid", 32'(out_valid), 32'(ov));
    if (ov) chk("sum", 32'(sum), 32'(sv));
    chk("word_valid", 32'(word_valid), 32'(wv));
    chk("frame_err", 32'(frame_err), 32'(fe));
    chk("word_sum", 32'(word_sum), exp_ws);
    chk("carry_out", 32'(carry_out), 32'(exp_co));
    chk("overflow", 32'(overflow), 32'(exp_of));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      chk_out(1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  // Send nbits of a word; nbits < W abandons it. gap_pct sets stall density.
  task automatic send_word(input logic [31:0] av, input logic [31:0] bv, input logic sb,
                           input int nbits, input int gap_pct);
    logic [31:0] res;
    logic co, of, sa, sbit, sr;
    av &= MASK; bv &= MASK;
    if (sb) begin
      res = (av - bv) & MASK;
      co  = (av >= bv);
    end else begin
      res = (av + bv) & MASK;
      co  = ((av + bv) >> W) != 0;
    end
    sa = av[W-1]; sbit = bv[W-1]; sr = res[W-1];
    of = sb ? ((sa != sbit) && (sr != sa)) : ((sa == sbit) && (sr != sa));
    for (int k = 0; k < nbits; k++) begin
      for (int g = 0; g < 3 && int'($urandom_range(99)) < gap_pct; g++) idle(1);
      cyc(1'b1, k == 0, (k == 0) ? sb : 1'($urandom), av[k], bv[k]);
      if (k == W-1) begin
        exp_ws = res; exp_co = co; exp_of = of;
      end
      chk_out(1'b1, res[k], k == W-1, 1'b0);
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_out(1'b0, 1'b0, 1'b0, 1'b0);

    send_word(32'h35, 32'h4A, 1'b0, W, 0);
    chk("w_35_4a", 32'(word_sum), 32'h7F);
    send_word(32'h7F, 32'h01, 1'b0, W, 0);
    chk("w_7f_01", {30'd0, carry_out, overflow}, 32'b01);
    send_word(32'hFF, 32'h01, 1'b0, W, 0);
    chk("w_ff_01", {30'd0, carry_out, overflow}, 32'b10);
    send_word(32'h05, 32'h07, 1'b1, W, 0);
    chk("w_05m07", 32'(word_sum), 32'hFE);
    send_word(32'h80, 32'h01, 1'b1, W, 0);
    chk("w_80m01", {30'd0, carry_out, overflow}, 32'b11);
    idle(2);

    // Stalls mid-word
    send_word(32'h35, 32'h4A, 1'b0, W, 60);
    idle(1);

    // Restart: abandoned partial, then a complete new word
    send_word(32'h5A, 32'hC3, 1'b1, 3, 0);
    send_word(32'h10, 32'h20, 1'b0, W, 0);
    chk("restart", 32'(word_sum), 32'h30);
    idle(1);

    // Reset mid-word, then framing error on an orphan bit
    send_word(32'hAB, 32'h11, 1'b0, 4, 0);
    rst = 1'b1;
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    exp_ws = '0; exp_co = 1'b0; exp_of = 1'b0;
    chk("rst_sum", 32'(sum), 32'd0);
    chk_out(1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    chk_out(1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    chk_out(1'b0, 1'b0, 1'b0, 1'b1);
    idle(1);

    // Randomized words: mixed ops, stalls, occasional abandons, back-to-back
    for (int i = 0; i < 60; i++) begin
      int n;
      n = ($urandom_range(9) == 0) ? int'($urandom_range(W-1, 1)) : W;
      send_word($urandom, $urandom, 1'($urandom), n, int'($urandom_range(40)));
      if ($urandom_range(3) == 0) idle(int'($urandom_range(2, 1)));
    end
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
endmodule
